// File: rtl/rt_pkg.sv
// Shared ray/triangle layouts, float constants and scanner FSM states.
package rt_pkg;

  localparam int unsigned FpW  = 32;
  localparam int unsigned RayW = 224;
  localparam int unsigned TriW = 384;

  typedef struct packed {
    logic [FpW-1:0] x;
    logic [FpW-1:0] y;
    logic [FpW-1:0] z;
  } vec3_t;

  typedef struct packed {
    vec3_t          org;
    vec3_t          dir;
    logic [FpW-1:0] tmax;
  } ray_t;

  typedef struct packed {
    vec3_t p0;
    vec3_t e1;
    vec3_t e2;
    vec3_t n;
  } tri_t;

  // Bit offsets of the fields within the flat vectors.
  localparam int unsigned RayTmaxLsb = 0;
  localparam int unsigned RayDirLsb  = 32;
  localparam int unsigned RayOrgLsb  = 128;
  localparam int unsigned TriNLsb    = 0;
  localparam int unsigned TriE2Lsb   = 96;
  localparam int unsigned TriE1Lsb   = 192;
  localparam int unsigned TriP0Lsb   = 288;

  localparam logic [FpW-1:0] FP_ONE  = 32'h3f80_0000;
  localparam logic [FpW-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait,
    StFin
  } state_e;

endpackage

// File: rtl/tri_fetch.sv
// Triangle memory req/ack handshake and the triangle register that feeds ist.
module tri_fetch
  import rt_pkg::*;
#(
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [IDX_W-1:0] base_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             tri_ack_i,
  input  logic [TriW-1:0]  tri_data_i,
  output logic             tri_req_o,
  output logic [IDX_W-1:0] tri_addr_o,
  output logic             accept_o,
  output logic [TriW-1:0]  tri_o
);

  logic [TriW-1:0] tri_q, tri_d;

  // IDX_W-bit sum wraps past the top of triangle memory by design.
  assign tri_req_o  = en_i;
  assign tri_addr_o = en_i ? (base_i + idx_i) : '0;
  assign accept_o   = en_i & tri_ack_i;

  always_comb begin
    tri_d = tri_q;
    if (accept_o) begin
      tri_d = tri_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tri_q <= '0;
    end else begin
      tri_q <= tri_d;
    end
  end

  assign tri_o = tri_q;

endmodule

// File: rtl/hit_scanner.sv
// Closest-hit scanner: walks a triangle range through ist, shrinking tmax on each hit.
module hit_scanner
  import rt_pkg::*;
#(
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [RayW-1:0]  ray_i,
  input  logic [IDX_W-1:0] tri_base_i,
  input  logic [IDX_W:0]   tri_count_i,
  output logic             tri_req_o,
  output logic [IDX_W-1:0] tri_addr_o,
  input  logic             tri_ack_i,
  input  logic [TriW-1:0]  tri_data_i,
  output logic             ist_valid_o,
  output logic [RayW-1:0]  ist_ray_o,
  output logic [TriW-1:0]  ist_tri_o,
  input  logic             ist_done_i,
  input  logic             ist_intersected_i,
  input  logic [FpW-1:0]   ist_t_i,
  input  logic [FpW-1:0]   ist_u_i,
  input  logic [FpW-1:0]   ist_v_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             hit_o,
  output logic [IDX_W-1:0] hit_idx_o,
  output logic [FpW-1:0]   hit_t_o,
  output logic [FpW-1:0]   hit_u_o,
  output logic [FpW-1:0]   hit_v_o
);

  state_e           state_q, state_d;
  ray_t             ray_q, ray_d, ray_in, ist_ray;
  logic [IDX_W-1:0] base_q, base_d;
  logic [IDX_W:0]   count_q, count_d, idx_q, idx_d, idx_inc;
  logic [FpW-1:0]   tmax_q, tmax_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic [FpW-1:0]   hit_t_q, hit_t_d, hit_u_q, hit_u_d, hit_v_q, hit_v_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             fetch_accept;

  tri_fetch #(
    .IDX_W(IDX_W)
  ) u_tri_fetch (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (state_q == StFetch),
    .base_i     (base_q),
    .idx_i      (idx_q[IDX_W-1:0]),
    .tri_ack_i  (tri_ack_i),
    .tri_data_i (tri_data_i),
    .tri_req_o  (tri_req_o),
    .tri_addr_o (tri_addr_o),
    .accept_o   (fetch_accept),
    .tri_o      (ist_tri_o)
  );

  assign ray_in  = ray_i;
  assign idx_inc = idx_q + {{IDX_W{1'b0}}, 1'b1};
  // done is registered so it trails FIN by one cycle, aligned with busy falling.
  assign done_d  = (state_q == StFin);

  always_comb begin
    state_d   = state_q;
    ray_d     = ray_q;
    base_d    = base_q;
    count_d   = count_q;
    idx_d     = idx_q;
    tmax_d    = tmax_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    hit_t_d   = hit_t_q;
    hit_u_d   = hit_u_q;
    hit_v_d   = hit_v_q;
    busy_d    = busy_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          ray_d   = ray_in;
          base_d  = tri_base_i;
          count_d = tri_count_i;
          tmax_d  = ray_in.tmax;
          idx_d   = '0;
          hit_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = (tri_count_i == '0) ? StFin : StFetch;
        end
      end
      StFetch: begin
        if (fetch_accept) begin
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (ist_done_i) begin
          if (ist_intersected_i) begin
            hit_d     = 1'b1;
            hit_idx_d = idx_q[IDX_W-1:0];
            hit_t_d   = ist_t_i;
            hit_u_d   = ist_u_i;
            hit_v_d   = ist_v_i;
            tmax_d    = ist_t_i;
          end
          idx_d   = idx_inc;
          state_d = (idx_inc == count_q) ? StFin : StFetch;
        end
      end
      StFin: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      ray_q     <= '0;
      base_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      tmax_q    <= FP_ZERO;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      hit_t_q   <= '0;
      hit_u_q   <= '0;
      hit_v_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ray_q     <= ray_d;
      base_q    <= base_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      tmax_q    <= tmax_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      hit_t_q   <= hit_t_d;
      hit_u_q   <= hit_u_d;
      hit_v_q   <= hit_v_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // ist sees the latched ray with its tmax replaced by the running nearest t.
  always_comb begin
    ist_ray      = ray_q;
    ist_ray.tmax = tmax_q;
  end

  assign ist_ray_o   = ist_ray;
  assign ist_valid_o = (state_q == StIssue);
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign hit_o       = hit_q;
  assign hit_idx_o   = hit_idx_q;
  assign hit_t_o     = hit_t_q;
  assign hit_u_o     = hit_u_q;
  assign hit_v_o     = hit_v_q;

endmodule
